// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming sliding-window generator for a row-major
// IMG_SIZE x IMG_SIZE pixel stream. Emits every valid KER_SIZE x KER_SIZE
// window (no padding) in raster order with a valid/ready handshake.
// Optional macro CONV_WINDOW_IDX_EN adds win_i/win_j outputs carrying the
// top-left coordinate of the window currently presented on win_out.
module conv_window_gen #(
  parameter int IMG_SIZE  = 7,
  parameter int KER_SIZE  = 3,
  parameter int WIDTH_BIT = 8
) (
  input  logic                                   clock,
  input  logic                                   nreset,
  input  logic [WIDTH_BIT-1:0]                   pix_in,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  output logic [KER_SIZE*KER_SIZE*WIDTH_BIT-1:0] win_out,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic                                   win_last
`ifdef CONV_WINDOW_IDX_EN
  ,
  output logic [WIDTH_BIT-1:0]                   win_i,
  output logic [WIDTH_BIT-1:0]                   win_j
`endif
);

  localparam int CW  = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int NLB = KER_SIZE - 1;
  localparam logic [CW-1:0] LAST_POS  = CW'(IMG_SIZE - 1);
  localparam logic [CW-1:0] FIRST_WIN = CW'(KER_SIZE - 1);

  logic                   accept;
  logic                   qualify;
  logic [CW-1:0]          col_q, col_d;
  logic [CW-1:0]          row_q, row_d;
  logic [CW-1:0]          rd_addr;
  logic                   win_valid_q, win_valid_d;
  logic                   win_last_q, win_last_d;
  logic [KER_SIZE-1:0][KER_SIZE-1:0][WIDTH_BIT-1:0] win_q, win_d;
  logic [NLB-1:0][WIDTH_BIT-1:0] lb_rd;

  // Single output stage: the window register itself is the output, so a new
  // pixel may only shift it once the current window has been taken.
  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign qualify   = (row_q >= FIRST_WIN) && (col_q >= FIRST_WIN);

  assign win_out   = win_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

  // Raster position of the next pixel; wraps per row and per frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == LAST_POS) begin
        col_d = '0;
        row_d = (row_q == LAST_POS) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Line buffers are read one cycle ahead at the next column, so the column
  // needed by an accept is already registered when the accept happens. The
  // write (current column) and read (next column) never collide because
  // consecutive columns always differ.
  assign rd_addr = nreset ? col_d : '0;

  // Line buffers: buffer 0 holds the oldest row. On each accept the column
  // shifts up by one buffer and pix_in enters the newest buffer.
  generate
    for (genvar gi = 0; gi < NLB; gi++) begin : g_lb
      logic [WIDTH_BIT-1:0] mem [IMG_SIZE];
      logic [WIDTH_BIT-1:0] rd_q;
      logic [WIDTH_BIT-1:0] wr_data;

      if (gi == NLB - 1) begin : g_newest
        assign wr_data = pix_in;
      end else begin : g_older
        assign wr_data = lb_rd[gi+1];
      end

      // Block-RAM style storage: one write port, registered read port.
      always_ff @(posedge clock) begin
        if (accept) begin
          mem[col_q] <= wr_data;
        end
        rd_q <= mem[rd_addr];
      end

      assign lb_rd[gi] = rd_q;
    end
  endgenerate

  // Window shift: move left by one column, load the new right column from
  // the line buffers (oldest on top) with pix_in at the bottom.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < KER_SIZE; r++) begin
        for (int c = 0; c < KER_SIZE - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < NLB; r++) begin
        win_d[r][KER_SIZE-1] = lb_rd[r];
      end
      win_d[NLB][KER_SIZE-1] = pix_in;
    end
  end

  // Output qualifiers: a window is valid only when the accepted pixel sits at
  // or beyond the bottom-right corner of a full window in the same row, which
  // also suppresses windows straddling a row edge or a frame edge.
  always_comb begin
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    if (accept) begin
      win_valid_d = qualify;
      win_last_d  = qualify && (row_q == LAST_POS) && (col_q == LAST_POS);
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_q       <= win_d;
    end
  end

`ifdef CONV_WINDOW_IDX_EN
  logic [WIDTH_BIT-1:0] win_i_q, win_i_d;
  logic [WIDTH_BIT-1:0] win_j_q, win_j_d;

  // Top-left coordinate of the window, captured with the window itself so it
  // holds under backpressure exactly like win_out.
  always_comb begin
    win_i_d = win_i_q;
    win_j_d = win_j_q;
    if (accept && qualify) begin
      win_i_d = WIDTH_BIT'(row_q - FIRST_WIN);
      win_j_d = WIDTH_BIT'(col_q - FIRST_WIN);
    end
  end

  // Coordinate registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      win_i_q <= '0;
      win_j_q <= '0;
    end else begin
      win_i_q <= win_i_d;
      win_j_q <= win_j_d;
    end
  end

  assign win_i = win_i_q;
  assign win_j = win_j_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed, table-driven bench for conv_window_gen.
// Define CONV_WINDOW_IDX_EN to also check the win_i/win_j outputs.
module tb_conv_window_gen;

  localparam int IMG  = 7;
  localparam int KER  = 3;
  localparam int W    = 8;
  localparam int NS   = IMG - KER + 1;
  localparam int NWIN = NS * NS;
  localparam int WW   = KER * KER * W;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic [W-1:0]  pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [WW-1:0] win_out;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic          win_last;
`ifdef CONV_WINDOW_IDX_EN
  logic [W-1:0]  win_i;
  logic [W-1:0]  win_j;
`endif

  conv_window_gen #(
    .IMG_SIZE (IMG),
    .KER_SIZE (KER),
    .WIDTH_BIT(W)
  ) dut (
    .clock    (clock),
    .nreset   (nreset),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .win_out  (win_out),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_last (win_last)
`ifdef CONV_WINDOW_IDX_EN
    ,
    .win_i    (win_i),
    .win_j    (win_j)
`endif
  );

  always #5 clock = ~clock;

  // One record per window of a frame: top-left pixel offset (relative to the
  // frame base value), window coordinate, and whether it closes the frame.
  typedef struct {
    int   tl;
    int   wi;
    int   wj;
    logic last;
  } vec_t;

  typedef struct {
    int base;
    int idx;
  } exp_t;

  // Hand-computed top-left pixel index of each window for a 7x7 image.
  int   tl_vals [NWIN] = '{0, 1, 2, 3, 4,
                           7, 8, 9, 10, 11,
                           14, 15, 16, 17, 18,
                           21, 22, 23, 24, 25,
                           28, 29, 30, 31, 32};
  vec_t tbl [NWIN];
  exp_t exp_q [$];
  int   pix_q [$];

  int   total = 0;
  int   bad = 0;
  int   win_cnt = 0;
  int   pr = 0;
  int   pc = 0;
  logic model_wv = 1'b0;

  function automatic logic [WW-1:0] make_win(input int base, input int tl);
    logic [WW-1:0] v;
    v = '0;
    for (int r = 0; r < KER; r++) begin
      for (int c = 0; c < KER; c++) begin
        v[(r*KER+c)*W +: W] = W'(base + tl + r*IMG + c);
      end
    end
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_win(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_frame(input int base);
    for (int n = 0; n < IMG*IMG; n++) pix_q.push_back(base + n);
    for (int k = 0; k < NWIN; k++) exp_q.push_back('{base: base, idx: k});
  endtask

  // Drives the queued pixels (optionally with bubbles and one 5-cycle stall
  // on the first window), consumes windows against the expectation queue and
  // checks win_valid/pix_ready against a small handshake model every cycle.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_stream(input string tag, input bit bubble, input bit bp,
                            input bit drain, input int max_cyc);
    int            cyc;
    int            bp_left;
    bit            bp_done;
    bit            acc;
    bit            hs;
    bit            qual;
    exp_t          e;
    logic [WW-1:0] held;
    cyc = 0;
    bp_left = 0;
    bp_done = 0;
    held = '0;
    while ((pix_q.size() > 0 || (drain && win_valid)) && cyc < max_cyc) begin
      pix_valid = (pix_q.size() > 0) && (!bubble || ($urandom_range(0, 1) == 1));
      pix_in    = (pix_q.size() > 0) ? W'(pix_q[0]) : '0;
      if (bp && model_wv && !bp_done) begin
        bp_left = 5;
        bp_done = 1;
        held    = win_out;
      end
      win_ready = (bp_left == 0);
      #1;
      if (bp_left > 0) begin
        check_win({tag, "/bp_hold_win"}, win_out, held);
        check_bit({tag, "/bp_hold_valid"}, win_valid, 1'b1);
        bp_left--;
      end
      check_bit({tag, "/pix_ready"}, pix_ready, !model_wv || win_ready);
      acc = pix_valid && pix_ready;
      hs  = win_valid && win_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check_int({tag, "/unexpected_win"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_win({tag, "/win_out"}, win_out, make_win(e.base, tbl[e.idx].tl));
          check_bit({tag, "/win_last"}, win_last, tbl[e.idx].last);
`ifdef CONV_WINDOW_IDX_EN
          check_int({tag, "/win_i"}, int'(win_i), tbl[e.idx].wi);
          check_int({tag, "/win_j"}, int'(win_j), tbl[e.idx].wj);
`endif
          $display("%s win %0d base=%0d tl=%0d last=%b out=%h", tag, win_cnt, e.base,
                   tbl[e.idx].tl, win_last, win_out);
          win_cnt++;
        end
      end
      qual = 0;
      if (acc) begin
        qual = (pr >= KER-1) && (pc >= KER-1);
        void'(pix_q.pop_front());
        if (pc == IMG-1) begin
          pc = 0;
          pr = (pr == IMG-1) ? 0 : pr + 1;
        end else begin
          pc++;
        end
      end
      @(posedge clock);
      #1;
      model_wv = acc ? qual : (win_ready ? 1'b0 : model_wv);
      check_bit({tag, "/win_valid"}, win_valid, model_wv);
      cyc++;
    end
    pix_valid = 1'b0;
    if (cyc >= max_cyc) begin
      total++;
      bad++;
      $display("FAIL %s/timeout: got %0d cycles required fewer than %0d", tag, cyc, max_cyc);
    end
  endtask

  initial begin
    for (int k = 0; k < NWIN; k++) begin
      tbl[k].tl   = tl_vals[k];
      tbl[k].wi   = k / NS;
      tbl[k].wj   = k % NS;
      tbl[k].last = (k == NWIN-1);
    end

    // Reset state
    nreset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_bit("reset/win_valid", win_valid, 1'b0);
    check_bit("reset/win_last", win_last, 1'b0);
    check_win("reset/win_out", win_out, '0);
`ifdef CONV_WINDOW_IDX_EN
    check_int("reset/win_i", int'(win_i), 0);
    check_int("reset/win_j", int'(win_j), 0);
`endif
    nreset = 1'b1;
    @(posedge clock);
    #1;
    check_bit("reset/pix_ready", pix_ready, 1'b1);

    // Continuous stream, one frame 0..48
    win_cnt = 0;
    load_frame(0);
    run_stream("cont", 1'b0, 1'b0, 1'b1, 400);
    check_int("cont/count", win_cnt, NWIN);
    check_int("cont/leftover", exp_q.size(), 0);

    // Backpressure on the first window
    win_cnt = 0;
    load_frame(0);
    run_stream("bp", 1'b0, 1'b1, 1'b1, 400);
    check_int("bp/count", win_cnt, NWIN);
    check_int("bp/leftover", exp_q.size(), 0);

    // Random input bubbles
    win_cnt = 0;
    load_frame(0);
    run_stream("bubble", 1'b1, 1'b0, 1'b1, 1000);
    check_int("bubble/count", win_cnt, NWIN);
    check_int("bubble/leftover", exp_q.size(), 0);

    // Back-to-back frames; second frame starts at value 100
    win_cnt = 0;
    load_frame(0);
    load_frame(100);
    run_stream("two", 1'b0, 1'b0, 1'b1, 800);
    check_int("two/count", win_cnt, 2*NWIN);
    check_int("two/leftover", exp_q.size(), 0);

    // Reset mid-frame after 20 pixels, with a window still pending
    win_cnt = 0;
    for (int n = 0; n < 20; n++) pix_q.push_back(n);
    for (int k = 0; k < 4; k++) exp_q.push_back('{base: 0, idx: k});
    run_stream("midrst", 1'b0, 1'b0, 1'b0, 100);
    check_int("midrst/pre_count", win_cnt, 3);
    check_bit("midrst/pending_valid", win_valid, 1'b1);
    nreset    = 1'b0;
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    win_ready = 1'b0;
    @(posedge clock);
    #1;
    check_bit("midrst/win_valid", win_valid, 1'b0);
    check_bit("midrst/win_last", win_last, 1'b0);
    check_win("midrst/win_out", win_out, '0);
    nreset    = 1'b1;
    pix_valid = 1'b0;
    exp_q.delete();
    pr = 0;
    pc = 0;
    model_wv = 1'b0;
    win_cnt = 0;
    load_frame(200);
    run_stream("postrst", 1'b0, 1'b0, 1'b1, 400);
    check_int("postrst/count", win_cnt, NWIN);
    check_int("postrst/leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming sliding-window generator that sits directly upstream of the 3x3 `conv` stage.
- Accepts a row-major pixel stream of an IMG_SIZE x IMG_SIZE image, one pixel per handshake.
- Emits every valid KER_SIZE x KER_SIZE window ("valid" convolution, no padding) in raster order, ready for `conv.inpMatrixI`.
- Replaces testbench-side window slicing with synthesizable line buffers and a valid/ready handshake.

Parameters:
- IMG_SIZE, 7, image width and height in pixels (>= KER_SIZE).
- KER_SIZE, 3, kernel/window edge length (>= 2).
- WIDTH_BIT, 8, pixel width in bits.

Ports:
- clock  input  1  rising-edge clock.
- nreset  input  1  synchronous reset, active low.
- pix_in  input  WIDTH_BIT  input pixel.
- pix_valid  input  1  pix_in is valid.
- pix_ready  output  1  block can accept a pixel this cycle.
- win_out  output  KER_SIZE*KER_SIZE*WIDTH_BIT  window, flattened. Element [r][c] sits at bits [(r*KER_SIZE+c)*WIDTH_BIT +: WIDTH_BIT]; r=0 is the oldest (top) row and c=0 the leftmost column.
- win_valid  output  1  win_out holds a window.
- win_ready  input  1  downstream accepts the window.
- win_last  output  1  qualifies the final window of a frame.

Behaviour:
- Clock and reset: one clock domain (`clock`). Reset is synchronous and active-low on `nreset`.
- Reset values: win_valid=0, win_last=0, win_out=0, row/column counters=0, window shift registers=0. pix_ready=1 one cycle after nreset is deasserted. Line-buffer RAM contents are not reset.
- Input accept: occurs when pix_valid && pix_ready. pix_ready = !win_valid || win_ready (single output stage, no skid buffer).
- Storage:
  - KER_SIZE-1 line buffers, each IMG_SIZE deep, indexed by column counter col.
  - A KER_SIZE x KER_SIZE window register.
- On each accept at position (row, col):
  - Shift the window left by one column.
  - Load the new rightmost column: rows 0..KER_SIZE-2 from the line buffers at col (oldest first), row KER_SIZE-1 from pix_in.
  - Shift the line buffers up at col, with pix_in entering the newest line buffer.
- Output timing:
  - win_valid asserts the cycle after an accept with row >= KER_SIZE-1 and col >= KER_SIZE-1. Latency is 1 cycle.
  - Otherwise win_valid clears once win_ready is high.
  - win_out and win_last must stay stable while win_valid && !win_ready.
- Counters:
  - col increments per accept and wraps IMG_SIZE-1 -> 0, incrementing row.
  - row wraps IMG_SIZE-1 -> 0 at end of frame. The next frame starts without any idle cycle.
- Row-boundary windows: never emitted. The col guard suppresses them even though the shift register holds mixed columns.
- Frame count and end of frame: (IMG_SIZE-KER_SIZE+1)^2 windows per frame, i.e. 25 for the defaults. win_last=1 only on the window produced by the accept at (IMG_SIZE-1, IMG_SIZE-1).
- Frame-to-frame isolation: the first KER_SIZE-1 rows of a new frame produce no windows, so no stale rows from the previous frame leak out.
- Simultaneous events: an accept in the same cycle as win_valid && win_ready is legal. The window is replaced and win_valid stays high if the new position qualifies.
- Reset mid-frame: nreset=0 drops win_valid immediately at the edge and clears the counters. The next pixel is (0,0).
- pix_valid bubbles: state is held and nothing is emitted.

Optional Feature:
- Macro: CONV_WINDOW_IDX_EN.
- When defined, adds two output ports, win_i and win_j, each WIDTH_BIT wide. They give the top-left coordinate of the current window (row-KER_SIZE+1, col-KER_SIZE+1), are registered alongside win_out, reset to 0, and are stable under backpressure. This matches the `indexMatrix` i/j convention.
- When not defined, the ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Continuous stream: 7x7 frame, pixel value = index 0..48, pix_valid and win_ready held high.
  - First win_valid occurs 1 cycle after pixel 16 is accepted, with win_out = {0,1,2,7,8,9,14,15,16}.
  - Exactly 25 windows are produced.
  - Last window is {32,33,34,39,40,41,46,47,48} with win_last=1; win_last=0 on all others.
- Backpressure: win_ready=0 for 5 cycles while the window at (0,0) is valid.
  - pix_ready=0 and win_out is stable throughout.
  - When released, the window sequence continues with no loss or duplication.
- Input bubbles: pix_valid toggles pseudo-randomly at 50%. The window sequence is identical to the continuous case and win_valid never asserts without a preceding accept.
- Row boundary and back-to-back frames: two frames sent consecutively, the second with values 100..148.
  - No window spans a row edge.
  - The first window of frame 2 is {100,101,102,107,108,109,114,115,116}.
  - Total window count is 50.
- Reset mid-operation: nreset pulsed low for 1 cycle after 20 pixels.
  - win_valid=0 and win_last=0 in the cycle after reset.
  - A fresh frame then produces the correct 25 windows starting from (0,0).
- With CONV_WINDOW_IDX_EN defined: rerun the continuous scenario. win_i/win_j step (0,0),(0,1)..(0,4),(1,0)..(4,4) in lockstep with the windows.
